// File: rtl/jtkicker_gfx_arb.sv
// rtl/jtkicker_gfx_arb.sv - shared graphics ROM arbiter for scroll and object fetchers (optional abort: JTKICKER_ARB_ABORT_EN)
module jtkicker_gfx_arb #(
  parameter int MAX_SKIP = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [12:0] scr_addr,
  input  logic        scr_cs,
  output logic [31:0] scr_data,
  output logic        scr_ok,
  input  logic [13:0] obj_addr,
  input  logic        obj_cs,
  output logic [31:0] obj_data,
  output logic        obj_ok,
  output logic [14:0] rom_addr,
  output logic        rom_cs,
  input  logic [31:0] rom_data,
  input  logic        rom_ok
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT1, ST_WAIT} state_t;

  localparam logic [2:0] SKIP_MAX = 3'(MAX_SKIP);

  state_t      state, state_nx;
  logic        cur_sel, cur_sel_nx;     // 0: scroll owns the port, 1: objects
  logic [13:0] cur_addr, cur_addr_nx;
  logic [12:0] scr_tag, scr_tag_nx;
  logic [13:0] obj_tag, obj_tag_nx;
  logic        scr_valid, scr_valid_nx;
  logic        obj_valid, obj_valid_nx;
  logic [31:0] scr_data_nx, obj_data_nx;
  logic [2:0]  skip_cnt, skip_nx;
  logic [14:0] rom_addr_nx;
  logic        rom_cs_nx;
  logic        scr_pend, obj_pend, obj_win, abort;

  assign scr_ok   = scr_cs & scr_valid & (scr_addr == scr_tag);
  assign obj_ok   = obj_cs & obj_valid & (obj_addr == obj_tag);
  assign scr_pend = scr_cs & ~scr_ok;
  assign obj_pend = obj_cs & ~obj_ok;
  // Objects win when alone, or when scroll has used up its run of grants
  assign obj_win  = obj_pend & (~scr_pend | (skip_cnt == SKIP_MAX));

`ifdef JTKICKER_ARB_ABORT_EN
  // The owner moved to a new address: the word in flight is no longer wanted
  assign abort = cur_sel ? (obj_cs & (obj_addr != cur_addr))
                         : (scr_cs & ({1'b0, scr_addr} != cur_addr));
`else
  assign abort = 1'b0;
`endif

  // Next-state and next-register values for the access sequencer
  always_comb begin
    state_nx     = state;
    cur_sel_nx   = cur_sel;
    cur_addr_nx  = cur_addr;
    scr_tag_nx   = scr_tag;
    obj_tag_nx   = obj_tag;
    scr_valid_nx = scr_valid;
    obj_valid_nx = obj_valid;
    scr_data_nx  = scr_data;
    obj_data_nx  = obj_data;
    skip_nx      = skip_cnt;
    rom_addr_nx  = rom_addr;
    rom_cs_nx    = rom_cs;
    case (state)
      ST_IDLE: begin
        if (scr_pend | obj_pend) begin
          rom_cs_nx = 1'b1;
          state_nx  = ST_WAIT1;
          if (obj_win) begin
            cur_sel_nx   = 1'b1;
            cur_addr_nx  = obj_addr;
            obj_tag_nx   = obj_addr;
            obj_valid_nx = 1'b0;
            rom_addr_nx  = {1'b1, obj_addr};
            skip_nx      = 3'd0;
          end else begin
            cur_sel_nx   = 1'b0;
            cur_addr_nx  = {1'b0, scr_addr};
            scr_tag_nx   = scr_addr;
            scr_valid_nx = 1'b0;
            rom_addr_nx  = {2'b00, scr_addr};
            if (obj_pend && (skip_cnt < SKIP_MAX)) skip_nx = skip_cnt + 3'd1;
          end
        end
      end
      ST_WAIT1: begin
        // rom_ok may still be high from the previous access; not trusted here
        if (abort) begin
          rom_cs_nx = 1'b0;
          state_nx  = ST_IDLE;
        end else begin
          state_nx  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (abort) begin
          rom_cs_nx = 1'b0;
          state_nx  = ST_IDLE;
        end else if (rom_ok) begin
          rom_cs_nx = 1'b0;
          state_nx  = ST_IDLE;
          if (cur_sel) begin
            obj_data_nx  = rom_data;
            obj_valid_nx = 1'b1;
          end else begin
            scr_data_nx  = rom_data;
            scr_valid_nx = 1'b1;
          end
        end
      end
      default: begin
        rom_cs_nx = 1'b0;
        state_nx  = ST_IDLE;
      end
    endcase
  end

  // Register bank; reset drops rom_cs at once and forgets any partial access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cur_sel   <= 1'b0;
      cur_addr  <= '0;
      scr_tag   <= '0;
      obj_tag   <= '0;
      scr_valid <= 1'b0;
      obj_valid <= 1'b0;
      scr_data  <= '0;
      obj_data  <= '0;
      skip_cnt  <= '0;
      rom_addr  <= '0;
      rom_cs    <= 1'b0;
    end else begin
      state     <= state_nx;
      cur_sel   <= cur_sel_nx;
      cur_addr  <= cur_addr_nx;
      scr_tag   <= scr_tag_nx;
      obj_tag   <= obj_tag_nx;
      scr_valid <= scr_valid_nx;
      obj_valid <= obj_valid_nx;
      scr_data  <= scr_data_nx;
      obj_data  <= obj_data_nx;
      skip_cnt  <= skip_nx;
      rom_addr  <= rom_addr_nx;
      rom_cs    <= rom_cs_nx;
    end
  end

endmodule

// File: tb/tb_jtkicker_gfx_arb.sv
// tb/tb_jtkicker_gfx_arb.sv - directed bench for jtkicker_gfx_arb (covers JTKICKER_ARB_ABORT_EN builds too)
module tb_jtkicker_gfx_arb;

  logic        clk;
  logic        rst_n;
  logic [12:0] scr_addr;
  logic        scr_cs;
  logic [31:0] scr_data;
  logic        scr_ok;
  logic [13:0] obj_addr;
  logic        obj_cs;
  logic [31:0] obj_data;
  logic        obj_ok;
  logic [14:0] rom_addr;
  logic        rom_cs;
  logic [31:0] rom_data;
  logic        rom_ok;

  jtkicker_gfx_arb #(.MAX_SKIP(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .scr_addr(scr_addr), .scr_cs(scr_cs), .scr_data(scr_data), .scr_ok(scr_ok),
    .obj_addr(obj_addr), .obj_cs(obj_cs), .obj_data(obj_data), .obj_ok(obj_ok),
    .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic        s_cs;
    logic [12:0] s_a;
    logic        o_cs;
    logic [13:0] o_a;
    logic        e_sok;
    logic        e_ook;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          lat     = 4;
  logic        tie_ok  = 1'b0;
  logic        use_fixed = 1'b0;
  logic [31:0] fixed_data = 32'h0;
  logic        auto_adv = 1'b0;
  int          auto_stop = 0;
  int          cs_cnt = 0;
  int          idle_cnt = 0;
  logic        have_prev = 1'b0;
  logic [14:0] acc_log[$];
  int          cs_len[$];
  int          idle_len[$];

  function automatic logic [31:0] romf(input logic [14:0] a);
    return {~a[7:0], 9'h0AB, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    acc_log.delete();
    cs_len.delete();
    idle_len.delete();
    have_prev = 1'b0;
    idle_cnt  = 0;
  endtask

  // One clock: sample the port, log accesses, then drive the ROM model
  task automatic cyc();
    @(posedge clk);
    #1;
    if (rom_cs) begin
      if (cs_cnt == 0) begin
        acc_log.push_back(rom_addr);
        if (have_prev) idle_len.push_back(idle_cnt);
      end
      cs_cnt++;
      idle_cnt = 0;
    end else begin
      if (cs_cnt != 0) begin
        cs_len.push_back(cs_cnt);
        have_prev = 1'b1;
      end
      cs_cnt = 0;
      idle_cnt++;
    end
    if (auto_adv && (cs_len.size() < auto_stop)) begin
      if (scr_ok) scr_addr = scr_addr + 13'd1;
      if (obj_ok) obj_addr = obj_addr + 14'd1;
    end
    rom_ok   = tie_ok || (rom_cs && (cs_cnt >= lat));
    rom_data = use_fixed ? fixed_data : romf(rom_addr);
  endtask

  task automatic wait_accesses(input int n, input int budget);
    int k;
    k = 0;
    while ((cs_len.size() < n) && (k < budget)) begin
      cyc();
      k++;
    end
    chk("access_count_in_budget", 32'(cs_len.size()), 32'(n));
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (rom_cs && (k < budget)) begin
      cyc();
      k++;
    end
    chk("idle_in_budget", 32'(rom_cs), 32'd0);
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    #1;
    cs_cnt = 0;
    rom_ok = tie_ok;
    cyc();
    rst_n  = 1'b1;
    clear_logs();
  endtask

  vec_t        tbl[8];
  logic [14:0] exp3[8];

  initial begin
    tbl[0] = '{1'b0, 13'h0400, 1'b0, 14'h0011, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 13'h0400, 1'b0, 14'h0011, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 13'h0401, 1'b1, 14'h0011, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 13'h0400, 1'b1, 14'h0012, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 13'h0400, 1'b1, 14'h0011, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 13'h0401, 1'b0, 14'h0012, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 13'h0000, 1'b1, 14'h0000, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 13'h0400, 1'b1, 14'h0011, 1'b0, 1'b1};
    exp3[0] = 15'h0300; exp3[1] = 15'h0301; exp3[2] = 15'h0302; exp3[3] = 15'h4050;
    exp3[4] = 15'h0303; exp3[5] = 15'h0304; exp3[6] = 15'h0305; exp3[7] = 15'h4051;

    rst_n = 1'b0; scr_cs = 1'b0; scr_addr = '0; obj_cs = 1'b0; obj_addr = '0;
    rom_ok = 1'b0; rom_data = '0;

    // Reset values
    cyc(); cyc();
    chk("rst_rom_cs", 32'(rom_cs), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_scr_data", scr_data, 32'd0);
    chk("rst_obj_data", obj_data, 32'd0);
    scr_cs = 1'b1; obj_cs = 1'b1;
    #1;
    chk("rst_scr_ok_tag0", 32'(scr_ok), 32'd0);
    chk("rst_obj_ok_tag0", 32'(obj_ok), 32'd0);
    scr_cs = 1'b0; obj_cs = 1'b0;
    rst_n = 1'b1;
    cyc();

    // Single scroll fetch, 4-cycle ROM
    use_fixed = 1'b1; fixed_data = 32'hDEADBEEF; lat = 4;
    scr_cs = 1'b1; scr_addr = 13'h0123;
    clear_logs();
    #1;
    chk("t1_scr_ok_before", 32'(scr_ok), 32'd0);
    cyc();
    chk("t1_rom_cs", 32'(rom_cs), 32'd1);
    chk("t1_rom_addr", 32'(rom_addr), 32'h0123);
    wait_accesses(1, 20);
    chk("t1_cs_len", 32'(cs_len[0]), 32'd4);
    chk("t1_scr_ok", 32'(scr_ok), 32'd1);
    chk("t1_scr_data", scr_data, 32'hDEADBEEF);
    repeat (5) cyc();
    chk("t1_no_refetch", 32'(acc_log.size()), 32'd1);
    chk("t1_rom_addr_held", 32'(rom_addr), 32'h0123);
    use_fixed = 1'b0;

    // Both pending, rom_ok tied high: scr,scr,scr,obj fairness pattern
    scr_cs = 1'b1; scr_addr = 13'h0300; obj_cs = 1'b1; obj_addr = 14'h0050;
    tie_ok = 1'b1;
    do_reset();
    auto_adv = 1'b1; auto_stop = 8;
    wait_accesses(8, 60);
    auto_adv = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t3_addr_%0d", i), 32'(acc_log[i]), 32'(exp3[i]));
      chk($sformatf("t3_cs_len_%0d", i), 32'(cs_len[i]), 32'd2);
    end
    for (int i = 0; i < 7; i++)
      chk($sformatf("t3_gap_%0d", i), 32'(idle_len[i]), 32'd1);
    chk("t3_obj_ok", 32'(obj_ok), 32'd1);
    chk("t3_obj_data", obj_data, romf(15'h4051));

    tie_ok = 1'b0; scr_cs = 1'b0; obj_cs = 1'b0;
    wait_idle(20);
    cyc();

    // Object address moves during WAIT
    obj_cs = 1'b1; obj_addr = 14'h0010;
    clear_logs();
    cyc();
    chk("t4_rom_cs", 32'(rom_cs), 32'd1);
    chk("t4_rom_addr", 32'(rom_addr), 32'h4010);
    cyc();
    obj_addr = 14'h0011;
    #1;
    chk("t4_obj_ok_moved", 32'(obj_ok), 32'd0);
`ifdef JTKICKER_ARB_ABORT_EN
    cyc();
    chk("t4_abort_cs_drop", 32'(rom_cs), 32'd0);
    chk("t4_abort_obj_ok", 32'(obj_ok), 32'd0);
    wait_accesses(2, 30);
    chk("t4_abort_len", 32'(cs_len[0]), 32'd2);
`else
    wait_accesses(1, 20);
    chk("t4_first_len", 32'(cs_len[0]), 32'd4);
    chk("t4_stale_obj_ok", 32'(obj_ok), 32'd0);
    chk("t4_stale_data", obj_data, romf(15'h4010));
    wait_accesses(2, 30);
`endif
    chk("t4_refetch_addr", 32'(acc_log[1]), 32'h4011);
    chk("t4_obj_ok", 32'(obj_ok), 32'd1);
    chk("t4_obj_data", obj_data, romf(15'h4011));

    // Reset pulse in the middle of a scroll access
    scr_cs = 1'b1; scr_addr = 13'h0400;
    clear_logs();
    cyc();
    chk("t5_rom_cs", 32'(rom_cs), 32'd1);
    chk("t5_rom_addr", 32'(rom_addr), 32'h0400);
    cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_rom_cs", 32'(rom_cs), 32'd0);
    chk("t5_rst_scr_ok", 32'(scr_ok), 32'd0);
    chk("t5_rst_obj_ok", 32'(obj_ok), 32'd0);
    chk("t5_rst_rom_addr", 32'(rom_addr), 32'd0);
    #2 rst_n = 1'b1;
    cs_cnt = 0; rom_ok = 1'b0;
    clear_logs();
    cyc();
    chk("t5_reissue_cs", 32'(rom_cs), 32'd1);
    chk("t5_reissue_addr", 32'(rom_addr), 32'h0400);
    wait_accesses(2, 40);
    chk("t5_second_addr", 32'(acc_log[1]), 32'h4011);
    chk("t5_scr_ok", 32'(scr_ok), 32'd1);
    chk("t5_obj_ok", 32'(obj_ok), 32'd1);
    chk("t5_scr_data", scr_data, romf(15'h0400));

    // Zero-latency hit table, applied between two clock edges
    cyc();
    for (int i = 0; i < 8; i++) begin
      scr_cs = tbl[i].s_cs; scr_addr = tbl[i].s_a;
      obj_cs = tbl[i].o_cs; obj_addr = tbl[i].o_a;
      #1;
      chk($sformatf("tbl_scr_ok_%0d", i), 32'(scr_ok), 32'(tbl[i].e_sok));
      chk($sformatf("tbl_obj_ok_%0d", i), 32'(obj_ok), 32'(tbl[i].e_ook));
      chk($sformatf("tbl_rom_cs_%0d", i), 32'(rom_cs), 32'd0);
    end
    scr_cs = 1'b1; scr_addr = 13'h0400; obj_cs = 1'b1; obj_addr = 14'h0011;
    clear_logs();
    repeat (4) cyc();
    chk("tbl_no_access", 32'(acc_log.size()), 32'd0);
    chk("tbl_scr_ok_held", 32'(scr_ok), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
